// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with pending scoreboard and sequenced soft clear
// Optional write-through read forwarding is enabled with REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DW      = 8,
  parameter int AW      = 2,
  parameter int ZERO_R0 = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          REG_WE,
  input  logic [AW-1:0] ND,
  input  logic [DW-1:0] DI,
  input  logic [AW-1:0] N1,
  input  logic [AW-1:0] N2,
  output logic [DW-1:0] Q1,
  output logic [DW-1:0] Q2,
  output logic          P1,
  output logic          P2,
  input  logic          MARK,
  input  logic [AW-1:0] NM,
  input  logic          CLR_REQ,
  output logic          BUSY,
  output logic          CLR_DONE,
  output logic          WR_DROP
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       rf_q [DEPTH];
  logic [DW-1:0]       rf_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic                drop_q, drop_d;
  logic                we_ok, mk_ok;

  // Entry 0 is untouchable when hardwired; such accesses never count as drops.
  assign we_ok = REG_WE && !((ZERO_R0 != 0) && (ND == '0));
  assign mk_ok = MARK && !((ZERO_R0 != 0) && (NM == '0));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rf_q    <= '{default: '0};
      pend_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_q    <= rf_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rf_d    = rf_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (we_ok) begin
          rf_d[ND]   = DI;
          pend_d[ND] = 1'b0;
        end
        // Mark is applied after the write so a same-entry mark wins.
        if (mk_ok) pend_d[NM] = 1'b1;
        if (CLR_REQ) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        rf_d[cnt_q]   = '0;
        pend_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + AW'(1);
        drop_d        = we_ok || mk_ok;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        drop_d  = we_ok || mk_ok;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    Q1 = rf_q[N1];
    Q2 = rf_q[N2];
    P1 = pend_q[N1];
    P2 = pend_q[N2];
`ifdef REGFILE_BYPASS_EN
    if (state_q == IDLE && we_ok) begin
      if (N1 == ND) begin
        Q1 = DI;
        P1 = mk_ok && (NM == ND);
      end
      if (N2 == ND) begin
        Q2 = DI;
        P2 = mk_ok && (NM == ND);
      end
    end
`endif
    if ((ZERO_R0 != 0) && (N1 == '0)) begin
      Q1 = '0;
      P1 = 1'b0;
    end
    if ((ZERO_R0 != 0) && (N2 == '0)) begin
      Q2 = '0;
      P2 = 1'b0;
    end
  end

  assign BUSY     = (state_q == CLEAR);
  assign CLR_DONE = (state_q == DONE);
  assign WR_DROP  = drop_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb (default and ZERO_R0 instances)
module tb_regfile_sb;

  logic       CLK = 1'b0;
  logic       RESET, REG_WE, MARK, CLR_REQ;
  logic [1:0] ND, N1, N2, NM;
  logic [7:0] DI, Q1, Q2;
  logic       P1, P2, BUSY, CLR_DONE, WR_DROP;

  logic       z_RESET, z_REG_WE, z_MARK, z_CLR_REQ;
  logic [1:0] z_ND, z_N1, z_N2, z_NM;
  logic [7:0] z_DI, z_Q1, z_Q2;
  logic       z_P1, z_P2, z_BUSY, z_CLR_DONE, z_WR_DROP;

  always #5 CLK = ~CLK;

  regfile_sb #(.DW(8), .AW(2), .ZERO_R0(0)) dut (
    .CLK(CLK), .RESET(RESET), .REG_WE(REG_WE), .ND(ND), .DI(DI),
    .N1(N1), .N2(N2), .Q1(Q1), .Q2(Q2), .P1(P1), .P2(P2),
    .MARK(MARK), .NM(NM), .CLR_REQ(CLR_REQ), .BUSY(BUSY),
    .CLR_DONE(CLR_DONE), .WR_DROP(WR_DROP)
  );

  regfile_sb #(.DW(8), .AW(2), .ZERO_R0(1)) dut_z (
    .CLK(CLK), .RESET(z_RESET), .REG_WE(z_REG_WE), .ND(z_ND), .DI(z_DI),
    .N1(z_N1), .N2(z_N2), .Q1(z_Q1), .Q2(z_Q2), .P1(z_P1), .P2(z_P2),
    .MARK(z_MARK), .NM(z_NM), .CLR_REQ(z_CLR_REQ), .BUSY(z_BUSY),
    .CLR_DONE(z_CLR_DONE), .WR_DROP(z_WR_DROP)
  );

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic ex(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    REG_WE = 1'b1; ND = a; DI = d;
    tick();
    REG_WE = 1'b0;
  endtask

  task automatic z_wr(input logic [1:0] a, input logic [7:0] d);
    z_REG_WE = 1'b1; z_ND = a; z_DI = d;
    tick();
    z_REG_WE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; REG_WE = 1'b0; MARK = 1'b0; CLR_REQ = 1'b0;
    ND = '0; N1 = '0; N2 = '0; NM = '0; DI = '0;
    z_RESET = 1'b0; z_REG_WE = 1'b0; z_MARK = 1'b0; z_CLR_REQ = 1'b0;
    z_ND = '0; z_N1 = '0; z_N2 = '0; z_NM = '0; z_DI = '0;
    #12;
    ex("rst_q1", 8'h00); ex("rst_q2", 8'h00); ex("rst_p1", 8'h00);
    ex("rst_busy", 8'h00); ex("rst_done", 8'h00); ex("rst_drop", 8'h00);
    chk(Q1); chk(Q2); chk({7'd0, P1}); chk({7'd0, BUSY}); chk({7'd0, CLR_DONE}); chk({7'd0, WR_DROP});
    @(negedge CLK);
    RESET = 1'b1; z_RESET = 1'b1;
    tick();

    // basic writes and reads
    ex("wr_q1", 8'hA5); ex("wr_q2", 8'h3C); ex("wr_p1", 8'h00); ex("wr_p2", 8'h00);
    wr(2'd2, 8'hA5);
    wr(2'd3, 8'h3C);
    N1 = 2'd2; N2 = 2'd3; #1;
    chk(Q1); chk(Q2); chk({7'd0, P1}); chk({7'd0, P2});

    // mark then clearing write
    ex("mark_p1", 8'h01);
    MARK = 1'b1; NM = 2'd1; tick(); MARK = 1'b0;
    N1 = 2'd1; #1;
    chk({7'd0, P1});
    ex("unmark_p1", 8'h00); ex("unmark_q1", 8'h77);
    wr(2'd1, 8'h77);
    chk({7'd0, P1}); chk(Q1);

    // same-edge write and mark, mark wins
    ex("wm_q1", 8'h5A); ex("wm_p1", 8'h01);
    REG_WE = 1'b1; ND = 2'd2; DI = 8'h5A; MARK = 1'b1; NM = 2'd2;
    tick();
    REG_WE = 1'b0; MARK = 1'b0; N1 = 2'd2; #1;
    chk(Q1); chk({7'd0, P1});

    // read during write on entry 0 (still reset value)
`ifdef REGFILE_BYPASS_EN
    ex("rdw_q1", 8'hFF);
`else
    ex("rdw_q1", 8'h00);
`endif
    ex("rdw_after", 8'hFF);
    N1 = 2'd0; REG_WE = 1'b1; ND = 2'd0; DI = 8'hFF; #1;
    chk(Q1);
    tick(); REG_WE = 1'b0; #1;
    chk(Q1);

    // fill, then soft clear with a discarded write
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    N1 = 2'd0; N2 = 2'd1;
    CLR_REQ = 1'b1; tick(); CLR_REQ = 1'b0;
    ex("c0_busy", 8'h01); ex("c0_q1", 8'h11); ex("c0_q2", 8'h22);
    chk({7'd0, BUSY}); chk(Q1); chk(Q2);
    tick();
    ex("c1_busy", 8'h01); ex("c1_q1", 8'h00); ex("c1_q2", 8'h22);
    chk({7'd0, BUSY}); chk(Q1); chk(Q2);
    REG_WE = 1'b1; ND = 2'd3; DI = 8'hEE;
    tick(); REG_WE = 1'b0;
    ex("c2_busy", 8'h01); ex("c2_drop", 8'h01); ex("c2_q2", 8'h00);
    chk({7'd0, BUSY}); chk({7'd0, WR_DROP}); chk(Q2);
    tick();
    ex("c3_busy", 8'h01); ex("c3_drop", 8'h00); ex("c3_done", 8'h00);
    chk({7'd0, BUSY}); chk({7'd0, WR_DROP}); chk({7'd0, CLR_DONE});
    tick();
    N1 = 2'd3; #1;
    ex("d_busy", 8'h00); ex("d_done", 8'h01); ex("d_q3", 8'h00);
    chk({7'd0, BUSY}); chk({7'd0, CLR_DONE}); chk(Q1);
    tick();
    ex("i_done", 8'h00); ex("i_busy", 8'h00);
    chk({7'd0, CLR_DONE}); chk({7'd0, BUSY});
    for (int i = 0; i < 4; i++) begin
      ex($sformatf("post_clr_q%0d", i), 8'h00);
      N1 = 2'(i); #1;
      chk(Q1);
    end

    // hardwired entry 0
    ex("z_q0", 8'h00); ex("z_drop", 8'h00); ex("z_p0", 8'h00);
    z_N1 = 2'd0;
    z_MARK = 1'b1; z_NM = 2'd0;
    z_wr(2'd0, 8'h55);
    z_MARK = 1'b0; #1;
    chk(z_Q1); chk({7'd0, z_WR_DROP}); chk({7'd0, z_P1});
    z_wr(2'd3, 8'h99);
    z_N2 = 2'd3;
    z_CLR_REQ = 1'b1; tick(); z_CLR_REQ = 1'b0;
    tick(); tick();
    ex("z_mid_busy", 8'h01); ex("z_mid_q3", 8'h99);
    chk({7'd0, z_BUSY}); chk(z_Q2);
    #2 z_RESET = 1'b0; #1;
    ex("z_rst_busy", 8'h00); ex("z_rst_q3", 8'h00);
    chk({7'd0, z_BUSY}); chk(z_Q2);
    @(negedge CLK); z_RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ex($sformatf("z_no_done%0d", i), 8'h00);
      chk({7'd0, z_CLR_DONE});
    end

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file: 2 async read ports, 1 sync write port.
- Per-register pending scoreboard for marking in-flight producers.
- Sequenced soft-clear engine.
- Successor to the fixed 4x8 CPU register file; sits between decode (read/mark) and writeback (write) in the CPU datapath.

Parameters:
DW, 8, data width in bits
AW, 2, address width; DEPTH = 2**AW entries (local, derived)
ZERO_R0, 0, 1 = entry 0 hardwired to zero and never pending

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
REG_WE  in  1  write enable
ND  in  AW  write address
DI  in  DW  write data
N1  in  AW  read address, port 1
N2  in  AW  read address, port 2
Q1  out  DW  read data, port 1 (combinational)
Q2  out  DW  read data, port 2 (combinational)
P1  out  1  pending flag of entry N1 (combinational)
P2  out  1  pending flag of entry N2 (combinational)
MARK  in  1  set pending for entry NM
NM  in  AW  mark address
CLR_REQ  in  1  soft-clear request
BUSY  out  1  clear sequence in progress
CLR_DONE  out  1  one-cycle pulse at end of clear
WR_DROP  out  1  registered one-cycle pulse: a write or mark was discarded

Behaviour:
- RESET=0 (async): all entries 0, all pending bits 0, state IDLE, counter 0. BUSY=0, CLR_DONE=0, WR_DROP=0. Outputs Q1/Q2/P1/P2 follow from the cleared array.
- States: IDLE, CLEAR, DONE.
- IDLE, write:
  - REG_WE=1 at the rising edge: RF[ND]<=DI and pend[ND]<=0.
  - MARK=1: pend[NM]<=1.
  - Same edge with NM==ND: data is written and pend ends at 1 (mark wins).
- Reads: Q1=RF[N1], Q2=RF[N2], P1=pend[N1], P2=pend[N2]. No latency, no pipeline.
- Read-during-write: without the bypass feature, reads return the old value until the edge.
- ZERO_R0=1:
  - Writes and marks to entry 0 are silently ignored; no WR_DROP.
  - Q reads as 0 and P reads as 0 whenever address is 0.
- IDLE, CLR_REQ=1 at an edge:
  - Any simultaneous write/mark in that cycle is still performed.
  - State goes to CLEAR with counter=0.
- CLEAR:
  - BUSY=1.
  - Each edge: RF[cnt]<=0, pend[cnt]<=0, cnt<=cnt+1.
  - After entry DEPTH-1 is cleared, go to DONE.
  - BUSY is high for exactly DEPTH cycles.
- DONE:
  - BUSY=0, CLR_DONE=1 for one cycle.
  - Next state IDLE; counter resets to 0.
- CLR_REQ during CLEAR or DONE: ignored, no queuing.
- REG_WE or MARK asserted during CLEAR or DONE: discarded, array unchanged. WR_DROP=1 in the following cycle.
- Reads during CLEAR: return current contents. Entries already cleared read 0; entries not yet cleared keep their old value.
- RESET asserted mid-clear: immediate full clear; state returns to IDLE; no CLR_DONE pulse.
- Addresses are always in range (DEPTH = 2**AW); no wrap handling is required beyond the counter terminating at DEPTH-1.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - In IDLE with REG_WE=1 (and the target is not a ZERO_R0 entry 0): any read port whose address equals ND returns DI on Q.
  - Its P returns 0, or 1 if MARK=1 with NM==ND in the same cycle.
  - This is a combinational write-through.
- Not defined: no forwarding; reads show the pre-edge contents and pend.
- No effect during CLEAR/DONE.

Test Plan:
- Reset, then write DI=8'hA5 to ND=2 and 8'h3C to ND=3; set N1=2, N2=3 -> Q1=8'hA5, Q2=8'h3C, P1=P2=0.
- MARK NM=1, then read N1=1 -> P1=1; later write DI=8'h77 to ND=1 -> P1=0, Q1=8'h77.
- Same-cycle REG_WE and MARK both to entry 2 -> Q=DI, pend[2]=1 afterwards.
- Fill all 4 entries, pulse CLR_REQ:
  - BUSY high for 4 cycles, then CLR_DONE pulses 1 cycle.
  - REG_WE during BUSY -> WR_DROP pulse, value not stored.
  - All Q=0 after.
- Bypass:
  - With REGFILE_BYPASS_EN, REG_WE ND=0 DI=8'hFF and N1=0 -> Q1=8'hFF in the same cycle.
  - Without the macro -> Q1 shows the old value until after the edge.
- ZERO_R0=1: write 8'h55 to ND=0 -> Q1 (N1=0) stays 0, no WR_DROP. Also drop RESET low midway through a clear -> BUSY=0 immediately, no CLR_DONE.
